// File: rtl/one_wire_pkg.sv
`default_nettype none
// ============================================================================
// one_wire_pkg : shared status codes, FSM states and CRC8 helper for the
//                1-Wire transaction sequencer.
// Rev 1.0
// ============================================================================
package one_wire_pkg;

  localparam logic [1:0] OW_ST_OK          = 2'd0;
  localparam logic [1:0] OW_ST_NO_PRESENCE = 2'd1;
  localparam logic [1:0] OW_ST_TIMEOUT     = 2'd2;
  localparam logic [1:0] OW_ST_CRC_ERR     = 2'd3;

  localparam logic [7:0] CRC8_POLY            = 8'h8C;
  localparam logic [7:0] OW_READ_FILL_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_FETCH = 3'd1,
    ST_WR_ISSUE = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RESP     = 3'd6
  } ow_state_e;

  // Dallas/Maxim CRC8, reflected form, data consumed LSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[7:1]};
      if (fb) c = c ^ CRC8_POLY;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/one_wire_crc8.sv
`default_nettype none
// ============================================================================
// one_wire_crc8 : byte-serial Dallas CRC8 accumulator (present only when
//                 OW_CRC8_CHECK_EN is defined).
// Rev 1.0
// ============================================================================
`ifdef OW_CRC8_CHECK_EN
module one_wire_crc8
  import one_wire_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 8'h00;
    end else if (i_clear) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_update(r_crc, i_byte);
    end
  end

  assign o_crc = r_crc;

endmodule
`endif
`default_nettype wire

// File: rtl/one_wire_txn_ctrl.sv
`default_nettype none
// ============================================================================
// one_wire_txn_ctrl : sequences N write / M read bytes through one_wire_top and
//                     returns one status per transaction.
// Option macro: OW_CRC8_CHECK_EN (Dallas CRC8 check over the read bytes).
// Rev 1.0
// ============================================================================
module one_wire_txn_ctrl
  import one_wire_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] READ_FILL   = OW_READ_FILL_DEFAULT,
  localparam int        LW          = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [LW-1:0] req_wr_len,
  input  logic [LW-1:0] req_rd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_byte,
  output logic          rd_valid,
  output logic [7:0]    rd_byte,
  output logic          rsp_valid,
  output logic [1:0]    rsp_status,
  output logic          ow_enable,
  output logic          ow_start,
  output logic [7:0]    ow_tx_byte,
  input  logic          ow_busy,
  input  logic          ow_done,
  input  logic          ow_presence,
  input  logic          ow_rx_valid,
  input  logic [7:0]    ow_rx_byte
);

  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LW-1:0] c_max_len  = LW'(MAX_LEN);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CYC - 1);

  ow_state_e     r_state;
  logic [LW-1:0] r_wr_cnt;
  logic [LW-1:0] r_rd_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_first;
  logic          r_rx_seen;
  logic          r_enable;
  logic          r_ow_start;
  logic [7:0]    r_tx_byte;
  logic          r_rd_valid;
  logic [7:0]    r_rd_byte;
  logic          r_rsp_valid;
  logic [1:0]    r_rsp_status;
  logic [1:0]    r_status;

  logic [LW-1:0] w_wr_len;
  logic [LW-1:0] w_rd_len;
  logic          w_accept;
  logic          w_pres_fail;
  logic          w_timeout;
  logic          w_fill;
  logic          w_emit;
  logic [7:0]    w_emit_byte;
  logic [1:0]    w_final_status;

  assign w_wr_len    = (req_wr_len > c_max_len) ? c_max_len : req_wr_len;
  assign w_rd_len    = (req_rd_len > c_max_len) ? c_max_len : req_rd_len;
  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_pres_fail = r_first && !ow_presence;
  // r_tmo counts the ow_start cycle as 1, so this fires TIMEOUT_CYC cycles after the start pulse
  assign w_timeout   = (r_tmo >= c_tmo_last);
  // A read slot that completes without rx data still yields one output byte
  assign w_fill      = (r_state == ST_RD_WAIT) && ow_done && !ow_rx_valid && !r_rx_seen && !w_pres_fail;
  assign w_emit      = ((r_state == ST_RD_WAIT) && ow_rx_valid) || w_fill;
  assign w_emit_byte = ow_rx_valid ? ow_rx_byte : READ_FILL;

`ifdef OW_CRC8_CHECK_EN
  logic [LW-1:0] r_rd_len;
  logic [7:0]    w_crc;

  one_wire_crc8 u_crc8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_en    (w_emit),
    .i_byte  (w_emit_byte),
    .o_crc   (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_len <= '0;
    end else if (w_accept) begin
      r_rd_len <= w_rd_len;
    end
  end

  // Residue over data plus trailing device CRC is zero when intact
  assign w_final_status = ((r_status == OW_ST_OK) && (r_rd_len >= LW'(2)) && (w_crc != 8'h00))
                          ? OW_ST_CRC_ERR : r_status;
`else
  assign w_final_status = r_status;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_tmo        <= '0;
      r_first      <= 1'b0;
      r_rx_seen    <= 1'b0;
      r_enable     <= 1'b0;
      r_ow_start   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_rd_byte    <= 8'h00;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= OW_ST_OK;
      r_status     <= OW_ST_OK;
    end else begin
      r_enable    <= 1'b1;
      r_ow_start  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;

      if (w_emit) begin
        r_rd_valid <= 1'b1;
        r_rd_byte  <= w_emit_byte;
        r_rx_seen  <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wr_cnt <= w_wr_len;
            r_rd_cnt <= w_rd_len;
            r_status <= OW_ST_OK;
            r_first  <= 1'b1;
            r_state  <= ((w_wr_len == '0) && (w_rd_len == '0)) ? ST_RESP : ST_WR_FETCH;
          end
        end

        ST_WR_FETCH: begin
          if (r_wr_cnt == '0) begin
            r_state <= ST_RD_ISSUE;
          end else if (wr_valid) begin
            r_tx_byte <= wr_byte;
            r_wr_cnt  <= r_wr_cnt - 1'b1;
            r_state   <= ST_WR_ISSUE;
          end
        end

        ST_WR_ISSUE: begin
          if (!ow_busy) begin
            r_ow_start <= 1'b1;
            r_tmo      <= TW'(1);
            r_state    <= ST_WR_WAIT;
          end
        end

        ST_RD_ISSUE: begin
          if (!ow_busy) begin
            r_ow_start <= 1'b1;
            r_tx_byte  <= READ_FILL;
            r_tmo      <= TW'(1);
            r_rx_seen  <= 1'b0;
            r_rd_cnt   <= r_rd_cnt - 1'b1;
            r_state    <= ST_RD_WAIT;
          end
        end

        ST_WR_WAIT, ST_RD_WAIT: begin
          if (ow_done) begin
            r_first <= 1'b0;
            if (w_pres_fail) begin
              r_status <= OW_ST_NO_PRESENCE;
              r_state  <= ST_RESP;
            end else if ((r_state == ST_WR_WAIT) && (r_wr_cnt != '0)) begin
              r_state <= ST_WR_FETCH;
            end else if (r_rd_cnt != '0) begin
              r_state <= ST_RD_ISSUE;
            end else begin
              r_state <= ST_RESP;
            end
          end else if (w_timeout) begin
            r_status <= OW_ST_TIMEOUT;
            r_state  <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        ST_RESP: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_status <= w_final_status;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign wr_ready   = (r_state == ST_WR_FETCH) && (r_wr_cnt != '0);
  assign rd_valid   = r_rd_valid;
  assign rd_byte    = r_rd_byte;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign ow_enable  = r_enable;
  assign ow_start   = r_ow_start;
  assign ow_tx_byte = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_one_wire_txn_ctrl.sv
`default_nettype none
// ============================================================================
// tb_one_wire_txn_ctrl : directed bench for one_wire_txn_ctrl with a
//                        behavioural one_wire_top responder.
// Rev 1.0
// ============================================================================
module tb_one_wire_txn_ctrl;

  localparam int LW  = 5;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [LW-1:0] req_wr_len = '0;
  logic [LW-1:0] req_rd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [7:0]    wr_byte = 8'h00;
  logic          rd_valid;
  logic [7:0]    rd_byte;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic          ow_enable;
  logic          ow_start;
  logic [7:0]    ow_tx_byte;
  logic          ow_busy;
  logic          ow_done;
  logic          ow_presence;
  logic          ow_rx_valid;
  logic [7:0]    ow_rx_byte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  one_wire_txn_ctrl #(
    .MAX_LEN     (16),
    .TIMEOUT_CYC (TMO),
    .READ_FILL   (8'hFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr_len  (req_wr_len),
    .req_rd_len  (req_rd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_byte     (wr_byte),
    .rd_valid    (rd_valid),
    .rd_byte     (rd_byte),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .ow_enable   (ow_enable),
    .ow_start    (ow_start),
    .ow_tx_byte  (ow_tx_byte),
    .ow_busy     (ow_busy),
    .ow_done     (ow_done),
    .ow_presence (ow_presence),
    .ow_rx_valid (ow_rx_valid),
    .ow_rx_byte  (ow_rx_byte)
  );

  // one_wire_top responder: done after m_lat cycles, rx data popped for 0xFF slots
  int         m_lat = 3;
  bit         m_presence = 1'b1;
  bit         m_hang = 1'b0;
  logic [7:0] m_rx_q[$];
  int         m_cnt;
  bit         m_act;

  assign ow_presence = m_presence;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ow_busy     <= 1'b0;
      ow_done     <= 1'b0;
      ow_rx_valid <= 1'b0;
      ow_rx_byte  <= 8'h00;
      m_act       <= 1'b0;
      m_cnt       <= 0;
    end else begin
      ow_done     <= 1'b0;
      ow_rx_valid <= 1'b0;
      if (!m_act) begin
        if (ow_start) begin
          m_act   <= 1'b1;
          ow_busy <= 1'b1;
          m_cnt   <= m_lat;
        end
      end else if (!m_hang) begin
        if (m_cnt <= 1) begin
          ow_done <= 1'b1;
          ow_busy <= 1'b0;
          m_act   <= 1'b0;
          if (ow_tx_byte == 8'hFF && m_rx_q.size() > 0) begin
            ow_rx_valid <= 1'b1;
            ow_rx_byte  <= m_rx_q.pop_front();
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Write-byte source: a byte is consumed at the edge following a negedge with valid&&ready
  logic [7:0] wr_q[$];
  bit         wr_pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) wr_pend = 1'b0;
    if (wr_pend && wr_q.size() > 0) void'(wr_q.pop_front());
    wr_valid = (wr_q.size() > 0);
    wr_byte  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    wr_pend  = wr_valid && wr_ready;
  end

  // Event logs sampled 1 time unit after each active edge
  int         cyc = 0;
  logic [7:0] st_q[$];
  int         st_cyc[$];
  logic [7:0] rd_q[$];
  logic [1:0] rsp_q[$];
  int         rsp_cyc[$];
  int         busy_viol = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (ow_start) begin
      st_q.push_back(ow_tx_byte);
      st_cyc.push_back(cyc);
      if (ow_busy) busy_viol++;
    end
    if (rd_valid) rd_q.push_back(rd_byte);
    if (rsp_valid) begin
      rsp_q.push_back(rsp_status);
      rsp_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0] at8(input logic [7:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

`ifdef OW_CRC8_CHECK_EN
  function automatic logic [7:0] crc_ref(input logic [7:0] d[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb   = c[0] ^ d[i][b];
        c    = c >> 1;
        c[7] = fb;
        c[3] = c[3] ^ fb;
        c[2] = c[2] ^ fb;
      end
    end
    return c;
  endfunction
`endif

  task automatic clr();
    st_q.delete(); st_cyc.delete(); rd_q.delete(); rsp_q.delete(); rsp_cyc.delete();
  endtask

  task automatic send_req(input int wl, input int rl, output int t);
    @(negedge clk);
    req_wr_len = LW'(wl);
    req_rd_len = LW'(rl);
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    t = cyc;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    int n;
    n = 0;
    while (rsp_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (rsp_q.size() > 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || ow_enable !== 1'b0 || ow_start !== 1'b0 || rsp_valid !== 1'b0 ||
        rd_valid !== 1'b0 || wr_ready !== 1'b0 || ow_tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: req_ready=%b ow_enable=%b ow_start=%b rsp_valid=%b rd_valid=%b wr_ready=%b tx=%h, want 1 0 0 0 0 0 00",
               req_ready, ow_enable, ow_start, rsp_valid, rd_valid, wr_ready, ow_tx_byte);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ow_enable !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ow_enable=%b req_ready=%b, want 1 1", ow_enable, req_ready);
    end
  endtask

  task automatic test_zero_len();
    int t; bit ok;
    clr();
    send_req(0, 0, t);
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_q[0] !== 2'd0 || rsp_cyc[0] - t !== 1) begin
      errors++;
      $display("FAIL zero_len_rsp: seen=%0d status=%0d latency=%0d, want 1 0 1",
               rsp_q.size(), ok ? rsp_q[0] : 2'bxx, ok ? rsp_cyc[0] - t : -1);
    end
    checks++;
    if (st_q.size() != 0) begin
      errors++;
      $display("FAIL zero_len_bus: starts=%0d, want 0", st_q.size());
    end
  endtask

  task automatic test_write();
    int t; bit ok;
    clr();
    wr_q.push_back(8'hCC);
    wr_q.push_back(8'h44);
    @(negedge clk);
    send_req(2, 0, t);
    wait_rsp(200, ok);
    checks++;
    if (st_q.size() != 2 || at8(st_q, 0) !== 8'hCC || at8(st_q, 1) !== 8'h44) begin
      errors++;
      $display("FAIL write_tx: starts=%0d tx0=%h tx1=%h, want 2 cc 44", st_q.size(), at8(st_q, 0), at8(st_q, 1));
    end
    checks++;
    if (st_cyc.size() == 0 || st_cyc[0] - t != 2) begin
      errors++;
      $display("FAIL write_first_issue: latency=%0d, want 2", st_cyc.size() ? st_cyc[0] - t : -1);
    end
    checks++;
    if (!ok || rsp_q[0] !== 2'd0) begin
      errors++;
      $display("FAIL write_rsp: status=%0d, want 0", ok ? rsp_q[0] : 2'bxx);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL write_streams: rd_valids=%0d wr_left=%0d, want 0 0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_presence();
    int t; bit ok;
    clr();
    m_presence = 1'b0;
    wr_q.push_back(8'hCC);
    wr_q.push_back(8'h44);
    send_req(2, 0, t);
    wait_rsp(200, ok);
    checks++;
    if (!ok || rsp_q[0] !== 2'd1 || st_q.size() != 1) begin
      errors++;
      $display("FAIL presence_rsp: status=%0d starts=%0d, want 1 1", ok ? rsp_q[0] : 2'bxx, st_q.size());
    end
    checks++;
    if (wr_q.size() != 1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL presence_wr: wr_left=%0d wr_ready=%b, want 1 0", wr_q.size(), wr_ready);
    end
    m_presence = 1'b1;
    wr_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int t; bit ok;
    logic [1:0] exp_st;
    logic [7:0] rx[$];
    clr();
    rx = '{8'h28, 8'hA1, 8'h5E};
    m_rx_q = rx;
    wr_q.push_back(8'h33);
`ifdef OW_CRC8_CHECK_EN
    exp_st = (crc_ref(rx) != 8'h00) ? 2'd3 : 2'd0;
`else
    exp_st = 2'd0;
`endif
    send_req(1, 3, t);
    wait_rsp(300, ok);
    checks++;
    if (st_q.size() != 4 || at8(st_q, 0) !== 8'h33 || at8(st_q, 1) !== 8'hFF ||
        at8(st_q, 2) !== 8'hFF || at8(st_q, 3) !== 8'hFF) begin
      errors++;
      $display("FAIL read_tx: starts=%0d tx=%h %h %h %h, want 4 33 ff ff ff",
               st_q.size(), at8(st_q, 0), at8(st_q, 1), at8(st_q, 2), at8(st_q, 3));
    end
    checks++;
    if (rd_q.size() != 3 || at8(rd_q, 0) !== 8'h28 || at8(rd_q, 1) !== 8'hA1 || at8(rd_q, 2) !== 8'h5E) begin
      errors++;
      $display("FAIL read_data: count=%0d bytes=%h %h %h, want 3 28 a1 5e",
               rd_q.size(), at8(rd_q, 0), at8(rd_q, 1), at8(rd_q, 2));
    end
    checks++;
    if (!ok || rsp_q[0] !== exp_st) begin
      errors++;
      $display("FAIL read_rsp: status=%0d, want %0d", ok ? rsp_q[0] : 2'bxx, exp_st);
    end
    checks++;
    if (busy_viol != 0) begin
      errors++;
      $display("FAIL start_while_busy: count=%0d, want 0", busy_viol);
    end
  endtask

  task automatic test_saturate();
    int t; bit ok; int bad;
    logic [1:0] exp_st;
    logic [7:0] fill[$];
    clr();
    m_rx_q.delete();
    for (int i = 0; i < 16; i++) fill.push_back(8'hFF);
`ifdef OW_CRC8_CHECK_EN
    exp_st = (crc_ref(fill) != 8'h00) ? 2'd3 : 2'd0;
`else
    exp_st = 2'd0;
`endif
    send_req(0, 20, t);
    wait_rsp(600, ok);
    bad = 0;
    foreach (rd_q[i]) if (rd_q[i] !== 8'hFF) bad++;
    checks++;
    if (st_q.size() != 16 || rd_q.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL saturate_len: starts=%0d rd_valids=%0d non_fill=%0d, want 16 16 0", st_q.size(), rd_q.size(), bad);
    end
    checks++;
    if (!ok || rsp_q[0] !== exp_st) begin
      errors++;
      $display("FAIL saturate_rsp: status=%0d, want %0d", ok ? rsp_q[0] : 2'bxx, exp_st);
    end
  endtask

  task automatic test_timeout();
    int t; bit ok;
    clr();
    m_hang = 1'b1;
    wr_q.push_back(8'hAA);
    send_req(1, 0, t);
    wait_rsp(400, ok);
    checks++;
    if (!ok || rsp_q[0] !== 2'd2 || st_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_rsp: status=%0d starts=%0d, want 2 1", ok ? rsp_q[0] : 2'bxx, st_q.size());
    end
    checks++;
    if (!ok || st_cyc.size() == 0 || rsp_cyc[0] - st_cyc[0] != TMO) begin
      errors++;
      $display("FAIL timeout_cycles: got=%0d, want %0d",
               (ok && st_cyc.size() > 0) ? rsp_cyc[0] - st_cyc[0] : -1, TMO);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_hang = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef OW_CRC8_CHECK_EN
  task automatic test_crc();
    int t; bit ok;
    logic [7:0] rom[$];
    clr();
    rom = '{8'h28, 8'hFF, 8'h4B, 8'h46, 8'h92, 8'h16, 8'h03};
    rom.push_back(crc_ref(rom));
    m_rx_q = rom;
    send_req(0, 8, t);
    wait_rsp(300, ok);
    checks++;
    if (!ok || rsp_q[0] !== 2'd0 || rd_q.size() != 8 || at8(rd_q, 7) !== rom[7]) begin
      errors++;
      $display("FAIL crc_good: status=%0d count=%0d last=%h, want 0 8 %h",
               ok ? rsp_q[0] : 2'bxx, rd_q.size(), at8(rd_q, 7), rom[7]);
    end
    clr();
    rom[3] = rom[3] ^ 8'h01;
    m_rx_q = rom;
    send_req(0, 8, t);
    wait_rsp(300, ok);
    checks++;
    if (!ok || rsp_q[0] !== 2'd3) begin
      errors++;
      $display("FAIL crc_bad: status=%0d, want 3", ok ? rsp_q[0] : 2'bxx);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int t; bit ok; int n;
    clr();
    m_lat  = 10;
    m_rx_q = '{8'h11, 8'h22};
    send_req(0, 2, t);
    n = 0;
    while (st_q.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (st_q.size() == 0) begin
      errors++;
      $display("FAIL midrst_start: starts=0, want 1");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || ow_start !== 1'b0 || rsp_valid !== 1'b0 || rd_valid !== 1'b0 ||
        ow_enable !== 1'b0 || ow_tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: req_ready=%b start=%b rsp=%b rd=%b en=%b tx=%h, want 1 0 0 0 0 00",
               req_ready, ow_start, rsp_valid, rd_valid, ow_enable, ow_tx_byte);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_lat = 3;
    m_rx_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_silent: rsp=%0d rd=%0d, want 0 0", rsp_q.size(), rd_q.size());
    end
    clr();
    m_rx_q = '{8'h9A};
    wr_q.push_back(8'h55);
    send_req(1, 1, t);
    wait_rsp(200, ok);
    checks++;
    if (!ok || rsp_q[0] !== 2'd0 || st_q.size() != 2 || at8(st_q, 0) !== 8'h55 || at8(rd_q, 0) !== 8'h9A) begin
      errors++;
      $display("FAIL midrst_recover: status=%0d starts=%0d tx0=%h rd0=%h, want 0 2 55 9a",
               ok ? rsp_q[0] : 2'bxx, st_q.size(), at8(st_q, 0), at8(rd_q, 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_len();
    test_write();
    test_presence();
    test_read();
    test_saturate();
    test_timeout();
`ifdef OW_CRC8_CHECK_EN
    test_crc();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
